// File: rtl/gf_mul_arb_pkg.sv
// Shared GF(2^8) definitions for the multiplier arbiter: field width, reduction polynomial,
// requester-index width and a combinational field multiply.
package gf_mul_arb_pkg;

   localparam int GF_W = 8;
   localparam logic [GF_W-1:0] GF_POLY = 8'h1D;  // x^8 + x^4 + x^3 + x^2 + 1, x^8 term implied

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Shift-and-add multiply; each doubling of the multiplicand reduces immediately.
   function automatic logic [GF_W-1:0] gf_mult(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
      logic [GF_W-1:0] acc;
      logic [GF_W-1:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < GF_W; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[GF_W-1] ? ((x << 1) ^ GF_POLY) : (x << 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf_mul_arb_mul.sv
// gf_mul: GF(2^8) multiplier with optional input and output register stages (latency REG_IN+REG_OUT),
// no backpressure; accepts a new operand pair every cycle.
module gf_mul
   import gf_mul_arb_pkg::*;
#(
   parameter int REG_IN  = 1,
   parameter int REG_OUT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_vld,
   input  logic [GF_W-1:0] a,
   input  logic [GF_W-1:0] b,
   output logic [GF_W-1:0] p,
   output logic            done
);

   logic [GF_W-1:0] a_s;
   logic [GF_W-1:0] b_s;
   logic            vld_s;
   logic [GF_W-1:0] prod_d;

   generate
      if (REG_IN != 0) begin : g_reg_in
         logic [GF_W-1:0] a_q;
         logic [GF_W-1:0] b_q;
         logic            vld_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q   <= '0;
               b_q   <= '0;
               vld_q <= 1'b0;
            end else begin
               a_q   <= a;
               b_q   <= b;
               vld_q <= in_vld;
            end
         end
         assign a_s   = a_q;
         assign b_s   = b_q;
         assign vld_s = vld_q;
      end else begin : g_comb_in
         assign a_s   = a;
         assign b_s   = b;
         assign vld_s = in_vld;
      end
   endgenerate

   always_comb begin
      prod_d = gf_mult(a_s, b_s);
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [GF_W-1:0] prod_q;
         logic            done_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prod_q <= '0;
               done_q <= 1'b0;
            end else begin
               prod_q <= prod_d;
               done_q <= vld_s;
            end
         end
         assign p    = prod_q;
         assign done = done_q;
      end else begin : g_comb_out
         assign p    = prod_d;
         assign done = vld_s;
      end
   endgenerate

endmodule

// File: rtl/gf_mul_arb.sv
// Round-robin arbiter sharing one 2-cycle GF(2^8) multiplier; one issue per cycle, results MUL_LAT cycles after grant.
// Requests wait (held) until granted; GF_MUL_ARB_PRIO0_EN gives requester 0 absolute priority.
module gf_mul_arb
   import gf_mul_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int MUL_LAT = 2,
   localparam int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [GF_W*NUM_REQ-1:0] op_a,
   input  logic [GF_W*NUM_REQ-1:0] op_b,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [GF_W-1:0]         res,
   output logic                    res_valid,
   output logic [IDX_W-1:0]        res_id,
   output logic                    busy
);

   logic [IDX_W-1:0]   ptr_d, ptr_q;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_vld;
   logic               prio_hit;
   logic [IDX_W:0]     scan;
   logic [GF_W-1:0]    iss_a, iss_b;
   logic [MUL_LAT-1:0] vld_d, vld_q;
   logic [IDX_W-1:0]   id_d [MUL_LAT];
   logic [IDX_W-1:0]   id_q [MUL_LAT];
   logic               unused_mul_done;

   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      prio_hit = 1'b0;
      scan     = '0;
      gnt      = '0;
      // Scan from ptr with wrap; the extra scan bit keeps ptr+k from overflowing before the wrap.
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
         if (!gnt_vld && req[scan[IDX_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan[IDX_W-1:0];
         end
      end
`ifdef GF_MUL_ARB_PRIO0_EN
      if (req[0]) begin
         gnt_vld  = 1'b1;
         gnt_idx  = '0;
         prio_hit = 1'b1;
      end
`endif
      gnt_vld = gnt_vld & rst_n;
      if (gnt_vld) gnt[gnt_idx] = 1'b1;

      ptr_d = ptr_q;
      if (gnt_vld && !prio_hit)
         ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);

      iss_a = op_a[int'(gnt_idx)*GF_W +: GF_W];
      iss_b = op_b[int'(gnt_idx)*GF_W +: GF_W];
   end

   // Owner tracking lives here rather than in the multiplier so reset flushes it with the arbiter.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = gnt_vld;
      id_d[0]  = gnt_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         vld_q <= '0;
         for (int i = 0; i < MUL_LAT; i++) id_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         vld_q <= vld_d;
         for (int i = 0; i < MUL_LAT; i++) id_q[i] <= id_d[i];
      end
   end

   assign res_valid = vld_q[MUL_LAT-1];
   assign res_id    = id_q[MUL_LAT-1];
   assign busy      = |vld_q;

   // Two register stages: MUL_LAT must stay 2 to line up with this instance.
   gf_mul #(
      .REG_IN  (1),
      .REG_OUT (1)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (gnt_vld),
      .a      (iss_a),
      .b      (iss_b),
      .p      (res),
      .done   (unused_mul_done)
   );

endmodule

// File: tb/tb_gf_mul_arb.sv
// Self-checking bench for gf_mul_arb: directed grant/latency cases plus random traffic against a GF(2^8) scoreboard.
module tb_gf_mul_arb;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [8*N-1:0] op_a, op_b;
   logic [N-1:0] gnt;
   logic [7:0]   res;
   logic         res_valid;
   logic [1:0]   res_id;
   logic         busy;

   typedef struct {
      logic [7:0] res;
      int         id;
      int         due;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   mptr  = 0;

   gf_mul_arb #(.NUM_REQ(N), .MUL_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .res       (res),
      .res_valid (res_valid),
      .res_id    (res_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Carry-less product to 15 bits, then fold the high bits down with x^8 = x^4+x^3+x^2+1.
   function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] t;
      t = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) t = t ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (t[i]) t = t ^ (15'h11D << (i - 8));
      return t[7:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      op_a[8*i +: 8] = a;
      op_b[8*i +: 8] = b;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      step();
      rst_n = 1'b1;
      mptr  = 0;
   endtask

   // Scoreboard: results are popped before this cycle's grant is pushed.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
         chk("gnt_subset", 32'((gnt & ~req) == '0), 32'd1);
         if (res_valid) begin
            if (sb_q.size() == 0) begin
               chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("res", 32'(res), 32'(e.res));
               chk("res_id", 32'(res_id), 32'(e.id));
               chk("res_latency", 32'(cyc), 32'(e.due));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
               exp_t e;
               e.res = gf_ref(op_a[8*i +: 8], op_b[8*i +: 8]);
               e.id  = i;
               e.due = cyc + LAT;
               sb_q.push_back(e);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] eg;
      int           gi;
      rst_n = 1'b0;
      req   = 4'hF;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req = '0;
      step();
      rst_n = 1'b1;

      // Single request: 02*80 = 1D.
      step();
      req = 4'b0001;
      set_op(0, 8'h02, 8'h80);
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h1);
      chk("single_busy_c0", 32'(busy), 32'd0);
      step();
      req = '0;
      @(negedge clk);
      chk("single_busy_c1", 32'(busy), 32'd1);
      chk("single_vld_c1", 32'(res_valid), 32'd0);
      step();
      @(negedge clk);
      chk("single_busy_c2", 32'(busy), 32'd1);
      chk("single_vld_c2", 32'(res_valid), 32'd1);
      chk("single_res_c2", 32'(res), 32'h1D);
      step();
      @(negedge clk);
      chk("single_busy_c3", 32'(busy), 32'd0);

      // All requesters held: rotation 0,1,2,3,... with 03*03 = 05.
      do_reset();
      req = 4'hF;
      for (int i = 0; i < N; i++) set_op(i, 8'h03, 8'h03);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef GF_MUL_ARB_PRIO0_EN
         eg = 4'b0001;
`else
         eg = 4'(1 << (k % N));
`endif
         chk("rr_all_gnt", 32'(gnt), 32'(eg));
         step();
      end
      req = '0;
      repeat (3) step();

      // Back-to-back mixed operands from requesters 1 then 2.
      do_reset();
      req = 4'b0010;
      set_op(1, 8'h01, 8'hA7);
      @(negedge clk);
      chk("b2b_gnt1", 32'(gnt), 32'h2);
      step();
      req = 4'b0100;
      set_op(2, 8'h00, 8'hFF);
      @(negedge clk);
      chk("b2b_gnt2", 32'(gnt), 32'h4);
      step();
      req = '0;
      @(negedge clk);
      chk("b2b_res1", 32'(res), 32'hA7);
      chk("b2b_id1", 32'(res_id), 32'd1);
      step();
      @(negedge clk);
      chk("b2b_vld2", 32'(res_valid), 32'd1);
      chk("b2b_res2", 32'(res), 32'h00);
      chk("b2b_id2", 32'(res_id), 32'd2);
      step();

      // Reset one cycle after a grant drops the in-flight op and restarts the pointer.
      do_reset();
      req = 4'b0100;
      set_op(2, 8'h55, 8'h0F);
      @(negedge clk);
      chk("rstmid_gnt", 32'(gnt), 32'h4);
      step();
      req   = 4'b0001;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_vld", 32'(res_valid), 32'd0);
      chk("rstmid_gnt_in_rst", 32'(gnt), 32'd0);
      step();
      rst_n = 1'b1;
      req   = 4'b0110;
      set_op(1, 8'h10, 8'h10);
      @(negedge clk);
      chk("rstmid_vld_after", 32'(res_valid), 32'd0);
      chk("rstmid_next_gnt", 32'(gnt), 32'h2);
      step();
      req = '0;
      repeat (3) step();

      // A withdrawn request earns nothing and leaves the pointer alone.
      do_reset();
      req = 4'b1100;
      @(negedge clk);
      chk("wd_gnt", 32'(gnt), 32'h4);
      step();
      req = '0;
      @(negedge clk);
      chk("wd_none", 32'(gnt), 32'h0);
      step();
      req = 4'b1010;
      @(negedge clk);
      chk("wd_ptr", 32'(gnt), 32'h8);
      step();
      req = '0;
      repeat (3) step();

      // Random traffic against an independent round-robin model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req  = 4'($urandom_range(0, 15));
         op_a = $urandom;
         op_b = $urandom;
         eg   = '0;
         gi   = -1;
`ifdef GF_MUL_ARB_PRIO0_EN
         if (req[0]) begin
            eg = 4'b0001;
            gi = -2;
         end
`endif
         if (gi == -1) begin
            for (int k = 0; k < N; k++) begin
               if (gi == -1 && req[(mptr + k) % N]) gi = (mptr + k) % N;
            end
            if (gi >= 0) eg[gi] = 1'b1;
         end
         @(negedge clk);
         chk("rand_gnt", 32'(gnt), 32'(eg));
         if (gi >= 0) mptr = (gi + 1) % N;
         step();
      end
      req = '0;
      repeat (4) step();
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gf_mul_arb.md
GF_MUL_ARB -- requirements
Module: gf_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one GF(2^8) multiplier (range 2..8).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning the multiplier latency in cycles from issue to result.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  NUM_REQ  meaning per-requester operation valid, held until granted.
REQ-006 SHALL have port op_a  input  8*NUM_REQ  meaning the packed first operands, requester i at bits [8i+7:8i].
REQ-007 SHALL have port op_b  input  8*NUM_REQ  meaning the packed second operands, same packing as op_a.
REQ-008 SHALL have port gnt  output  NUM_REQ  meaning a one-hot grant, combinational from req and the priority pointer.
REQ-009 SHALL have port res  output  8  meaning the product op_a*op_b in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
REQ-010 SHALL have port res_valid  output  1  meaning res and res_id are valid this cycle.
REQ-011 SHALL have port res_id  output  clog2(NUM_REQ)  meaning the index of the requester that owns res.
REQ-012 SHALL have port busy  output  1  meaning at least one operation is in flight.

Function
- REQ-013 SHALL grant at most one requester per cycle; gnt[i]=1 only if req[i]=1; a request and its operands are consumed in the cycle in which gnt[i]=1.
- REQ-014 SHALL arbitrate round-robin: search starts at ptr; after a grant to i, ptr becomes (i+1) mod NUM_REQ; ptr is unchanged when nothing is granted.
- REQ-015 SHALL issue the granted operands to the multiplier in the grant cycle, sustaining one issue per cycle (full throughput, no bubbles).
- REQ-016 SHALL assert res_valid exactly MUL_LAT cycles after the grant cycle, with res_id equal to the granted index, via a reset-able valid/id shift pipeline of depth MUL_LAT.
- REQ-017 SHALL keep results in issue order; no result is dropped or duplicated.
- REQ-018 SHALL hold busy=1 whenever any valid stage in the pipeline is set, and busy=0 otherwise.
- REQ-019 SHALL grant a requester that deasserts req before its grant nothing, with no side effects.
- REQ-020 SHALL allow a requester that is still requesting after its grant to be granted again only after every other active requester has been served once.
- REQ-021 SHALL drive gnt=0 while rst_n=0.

Reset
- REQ-022 SHALL set ptr=0, every pipeline valid bit=0, res_valid=0, res_id=0, res=0 and busy=0 asynchronously when rst_n=0.
- REQ-023 SHALL discard in-flight operations on reset mid-operation; no res_valid pulse for them after rst_n rises.
- REQ-024 SHALL make the first grant after reset go to the lowest-index active requester.

Configuration
- REQ-025 SHALL honour macro GF_MUL_ARB_PRIO0_EN: when defined, req[0] always wins over the round-robin and ptr is not updated on a requester-0 grant; when undefined, all requesters are pure round-robin.

Structure
- REQ-026 SHALL place in a shared package: the reduction polynomial constant 8'h1D, the GF element width 8, and the requester-index width function.
- REQ-027 SHALL instantiate one gf_mul with REG_IN=1 and REG_OUT=1 (MUL_LAT=2) as its single sub-module, ignoring its done output in favour of the arbiter's own reset-able valid pipeline.

Verification
- REQ-028 Single request: req=0001, op_a[0]=02, op_b[0]=80 -> gnt=0001 in cycle 0; res=1D, res_id=0, res_valid=1 in cycle 2; busy=1 in cycles 1-2.
- REQ-029 All requesters held for 8 cycles, op pair (03,03) each -> grants 0,1,2,3,0,1,2,3; res=05 every cycle from cycle 2 to cycle 9, res_id following the same order.
- REQ-030 Back-to-back mixed operands: requester 1 (01,A7) then requester 2 (00,FF) -> res=A7 with id 1, then res=00 with id 2, on consecutive cycles.
- REQ-031 Reset mid-flight: assert rst_n=0 one cycle after a grant -> res_valid stays 0, busy=0, and the next grant goes to the lowest-index active requester.
- REQ-032 With GF_MUL_ARB_PRIO0_EN defined and req=1111 held -> requester 0 is granted every cycle; with it undefined -> grants rotate 0,1,2,3.
- REQ-033 Random req/operand traffic checked against a software GF(2^8) model -> every issued op returns exactly once, in order, with the correct res_id, and no two grants in one cycle.
